// File: rtl/aes_sbox_arbiter.sv
// Shares four AES S-box byte lanes between a SubBytes (128-bit state) requester
// and a SubWord (32-bit key word) requester, with round-robin arbitration.

module aes_S_box (
    input  logic [7:0] x,
    output logic [7:0] y
);
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[x];
endmodule

module aes_sbox_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         state_req,
    input  logic [127:0] state_in,
    output logic         state_ack,
    output logic         state_done,
    output logic [127:0] state_out,
    input  logic         key_req,
    input  logic [31:0]  word_in,
    output logic         key_ack,
    output logic         key_done,
    output logic [31:0]  word_out,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, KEY, STATE} fsm_t;
    typedef enum logic {LAST_KEY, LAST_STATE} last_t;

    fsm_t         fsm;
    last_t        last;
    logic [1:0]   idx;
    logic [127:0] op;
    logic [95:0]  work;
    logic [31:0]  lane_word;
    logic [31:0]  lane_res;
    logic         grant_key;
    logic         grant_state;

    // Ties go to whoever was not served last; grants only exist in IDLE.
    always_comb begin
        grant_key   = 1'b0;
        grant_state = 1'b0;
        if (fsm == IDLE && !rst) begin
            if (key_req && (!state_req || last == LAST_STATE))
                grant_key = 1'b1;
            else if (state_req)
                grant_state = 1'b1;
        end
    end

    assign key_ack   = grant_key;
    assign state_ack = grant_state;

    // A key word is captured into word 0 of the operand register, so idx=0 serves both jobs.
    always_comb begin
        // NOTE: assigning a default first keeps this block free of inferred latches.
        lane_word = op[127:96];
        case (idx)
            2'd1:    lane_word = op[95:64];
            2'd2:    lane_word = op[63:32];
            2'd3:    lane_word = op[31:0];
            default: lane_word = op[127:96];
        endcase
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        aes_S_box u_lane (
            .x (lane_word[8*i +: 8]),
            .y (lane_res[8*i +: 8])
        );
    end

    // NOTE: operand and work registers carry no reset; they are always written before being read.
    always_ff @(posedge clk) begin
        if (grant_state)
            op <= state_in;
        else if (grant_key)
            op[127:96] <= word_in;

        if (fsm == STATE) begin
            case (idx)
                2'd0:    work[95:64] <= lane_res;
                2'd1:    work[63:32] <= lane_res;
                2'd2:    work[31:0]  <= lane_res;
                default: ;
            endcase
        end
    end

    // busy spans from the cycle after the ack through the done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= IDLE;
            last       <= LAST_STATE;
            idx        <= 2'd0;
            state_out  <= '0;
            word_out   <= '0;
            state_done <= 1'b0;
            key_done   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values.
            state_done <= 1'b0;
            key_done   <= 1'b0;
            busy       <= (fsm != IDLE) || grant_key || grant_state;
            case (fsm)
                IDLE: begin
                    if (grant_key) begin
                        fsm  <= KEY;
                        last <= LAST_KEY;
                    end else if (grant_state) begin
                        fsm  <= STATE;
                        last <= LAST_STATE;
                    end
                end
                KEY: begin
                    word_out <= lane_res;
                    key_done <= 1'b1;
                    fsm      <= IDLE;
                end
                STATE: begin
                    if (idx == 2'd3) begin
                        state_out  <= {work, lane_res};
                        state_done <= 1'b1;
                        idx        <= 2'd0;
                        fsm        <= IDLE;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule
